// File: rtl/dp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dp_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one WIDTH-bit streaming datapath
//             port among NUM_REQ requesters. A grant lasts up to BURST_LEN
//             beats, or until the owner drops valid, and then rotates.
//  Revision : 1.0  initial release
// ============================================================================
module dp_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       dp_valid_o,
  output logic [WIDTH-1:0]           dp_data_o,
  input  logic                       dp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [IDW-1:0]   grant, grant_nxt;
  logic [CW-1:0]    beat_cnt, beat_cnt_nxt;
  logic [IDW-1:0]   scan_sel;
  logic             scan_hit;
  logic             busy;
  logic             owner_valid;
  logic             xfer;
  logic [WIDTH-1:0] slice [NUM_REQ];

  // Unpack the flat data bus and build the per-requester ready strobes
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_lane
    assign slice[n]       = req_data_i[n*WIDTH +: WIDTH];
    assign req_ready_o[n] = busy & (grant == IDW'(n)) & dp_ready_i;
  end

  assign busy        = (state == BUSY);
  assign owner_valid = req_valid_i[grant];
  assign dp_valid_o  = busy & owner_valid;
  assign dp_data_o   = busy ? slice[grant] : '0;
  assign xfer        = dp_valid_o & dp_ready_i;
  assign busy_o      = busy;
  assign grant_id_o  = grant;

  // Find the first valid requester scanning upward from ptr with wrap-around
  always_comb begin
    int idx;
    idx      = 0;
    scan_hit = 1'b0;
    scan_sel = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!scan_hit && req_valid_i[idx[IDW-1:0]]) begin
        scan_hit = 1'b1;
        scan_sel = idx[IDW-1:0];
      end
    end
  end

  // Next-state logic: one arbitration cycle in IDLE, burst counting in BUSY
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (scan_hit) begin
          state_nxt    = BUSY;
          grant_nxt    = scan_sel;
          beat_cnt_nxt = '0;
        end
      end
      BUSY: begin
        // Release when the owner goes idle or its last allowed beat moves
        if (!owner_valid || (xfer && (beat_cnt == LAST_BEAT))) begin
          state_nxt    = IDLE;
          ptr_nxt      = (grant == LAST_ID) ? '0 : grant + 1'b1;
          beat_cnt_nxt = '0;
        end else if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset so outputs drop without a clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_rr_arbiter
//  Purpose  : Self-checking bench for dp_rr_arbiter: first-grant vector table,
//             beat scoreboard per requester and burst log checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_rr_arbiter;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*W-1:0] req_data_i;
  logic [NR-1:0]   req_ready_o;
  logic            dp_valid_o;
  logic [W-1:0]    dp_data_o;
  logic            dp_ready_i;
  logic [1:0]      grant_id_o;
  logic            busy_o;

  dp_rr_arbiter #(.WIDTH(W), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .dp_valid_o  (dp_valid_o),
    .dp_data_o   (dp_data_o),
    .dp_ready_i  (dp_ready_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] mask;
    logic       rdy;
    int         exp_grant;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    int id;
    int beats;
    int start;
    int len;
  } burst_t;

  int           tests = 0;
  int           fails = 0;
  int           cycn  = 0;
  int           rdy_mode = 0;   // 0: always ready, 1: toggle, 2: never
  logic [W-1:0] srcq  [NR][$];  // beats the requester still has to send
  logic [W-1:0] exp_q [NR][$];  // scoreboard: beats expected on the datapath
  int           seq   [NR];
  burst_t       bursts[$];
  bit           in_burst = 1'b0;
  burst_t       cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int n, input int cnt);
    logic [W-1:0] d;
    for (int i = 0; i < cnt; i++) begin
      d = W'(n * 64 + seq[n]);
      seq[n]++;
      srcq[n].push_back(d);
      exp_q[n].push_back(d);
    end
  endtask

  task automatic drive();
    for (int n = 0; n < NR; n++) begin
      req_valid_i[n]           = (srcq[n].size() > 0);
      req_data_i[n*W +: W]     = (srcq[n].size() > 0) ? srcq[n][0] : '0;
    end
    case (rdy_mode)
      0:       dp_ready_i = 1'b1;
      1:       dp_ready_i = cycn[0];
      default: dp_ready_i = 1'b0;
    endcase
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, score transfers
  task automatic cyc();
    int           g;
    logic [W-1:0] e;
    @(negedge clk_i);
    drive();
    #1;
    if (busy_o && !in_burst) begin
      in_burst  = 1'b1;
      cur.id    = int'(grant_id_o);
      cur.beats = 0;
      cur.start = cycn;
      cur.len   = 0;
    end else if (!busy_o && in_burst) begin
      in_burst = 1'b0;
      cur.len  = cycn - cur.start;
      bursts.push_back(cur);
    end
    if (dp_valid_o && dp_ready_i) begin
      g = int'(grant_id_o);
      cur.beats++;
      if (exp_q[g].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: req %0d sent %0h with nothing expected", g, dp_data_o);
      end else begin
        e = exp_q[g].pop_front();
        chk("beat_data", 32'(dp_data_o), 32'(e));
      end
      if (srcq[g].size() > 0) e = srcq[g].pop_front();
    end
    cycn++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    dp_ready_i  = 1'b0;
    for (int n = 0; n < NR; n++) begin
      srcq[n].delete();
      exp_q[n].delete();
      seq[n] = 0;
    end
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i    = 1'b0;
    in_burst = 1'b0;
    bursts.delete();
    cycn     = 0;
    rdy_mode = 0;
  endtask

  // Assert reset between clock edges in the middle of a burst
  task automatic mid_reset(input int exp_gid);
    @(negedge clk_i);
    drive();
    #1;
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    chk("pre_rst_grant", 32'(grant_id_o), 32'(exp_gid));
    rst_i = 1'b1;
    #1;
    chk("rst_dp_valid", 32'(dp_valid_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_dp_data", 32'(dp_data_o), 32'd0);
    chk("rst_grant", 32'(grant_id_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i    = 1'b0;
    in_burst = 1'b0;
    bursts.delete();
    cycn     = 0;
    drive();
  endtask

  task automatic run_until_idle(input int bound);
    int n0;
    n0 = bursts.size();
    for (int i = 0; i < bound; i++) begin
      if (bursts.size() > n0) return;
      cyc();
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: no burst closed within %0d cycles", bound);
  endtask

  task automatic run_until_done(input int bound);
    bit pending;
    for (int i = 0; i < bound; i++) begin
      pending = in_burst;
      for (int n = 0; n < NR; n++) if (srcq[n].size() > 0) pending = 1'b1;
      if (!pending) return;
      cyc();
    end
    tests++;
    fails++;
    $display("FAIL done_timeout: traffic not drained within %0d cycles", bound);
  endtask

  task automatic check_burst(input int k, input int id, input int beats);
    if (k >= bursts.size()) begin
      tests++;
      fails++;
      $display("FAIL burst_missing: burst %0d absent, only %0d logged", k, bursts.size());
    end else begin
      chk($sformatf("burst%0d_id", k), 32'(bursts[k].id), 32'(id));
      chk($sformatf("burst%0d_beats", k), 32'(bursts[k].beats), 32'(beats));
    end
  endtask

  task automatic check_drained();
    for (int n = 0; n < NR; n++)
      chk($sformatf("drained_req%0d", n), 32'(exp_q[n].size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{mask: 4'b0001, rdy: 1'b1, exp_grant: 0, exp_ready: 4'b0001};
    vecs[1] = '{mask: 4'b0110, rdy: 1'b1, exp_grant: 1, exp_ready: 4'b0010};
    vecs[2] = '{mask: 4'b1100, rdy: 1'b0, exp_grant: 2, exp_ready: 4'b0000};
    vecs[3] = '{mask: 4'b1000, rdy: 1'b1, exp_grant: 3, exp_ready: 4'b1000};
    vecs[4] = '{mask: 4'b1111, rdy: 1'b1, exp_grant: 0, exp_ready: 4'b0001};
    vecs[5] = '{mask: 4'b1010, rdy: 1'b0, exp_grant: 1, exp_ready: 4'b0000};

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    dp_ready_i  = 1'b0;
    for (int n = 0; n < NR; n++) seq[n] = 0;

    // Reset values with requesters all valid and no clock edge yet
    req_valid_i = 4'hF;
    #1;
    chk("reset_dp_valid", 32'(dp_valid_o), 32'd0);
    chk("reset_req_ready", 32'(req_ready_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_grant", 32'(grant_id_o), 32'd0);
    do_reset();

    // First grant from reset: one IDLE cycle, then the scanned owner
    for (int v = 0; v < 6; v++) begin
      do_reset();
      rdy_mode = vecs[v].rdy ? 0 : 2;
      for (int n = 0; n < NR; n++) if (vecs[v].mask[n]) load(n, 3);
      cyc();
      chk($sformatf("v%0d_idle_busy", v), 32'(busy_o), 32'd0);
      chk($sformatf("v%0d_idle_valid", v), 32'(dp_valid_o), 32'd0);
      chk($sformatf("v%0d_idle_data", v), 32'(dp_data_o), 32'd0);
      chk($sformatf("v%0d_idle_ready", v), 32'(req_ready_o), 32'd0);
      cyc();
      chk($sformatf("v%0d_busy", v), 32'(busy_o), 32'd1);
      chk($sformatf("v%0d_grant", v), 32'(grant_id_o), 32'(vecs[v].exp_grant));
      chk($sformatf("v%0d_valid", v), 32'(dp_valid_o), 32'd1);
      chk($sformatf("v%0d_ready", v), 32'(req_ready_o), 32'(vecs[v].exp_ready));
      chk($sformatf("v%0d_data", v), 32'(dp_data_o), 32'(vecs[v].exp_grant * 64));
    end

    // Async reset while requester 1 owns the port; restart from requester 0
    do_reset();
    for (int n = 0; n < NR; n++) load(n, 8);
    for (int i = 0; i < 7; i++) cyc();
    mid_reset(1);
    cyc();
    chk("after_rst_first_grant", 32'(grant_id_o), 32'd0);

    // Single requester, 10 beats -> bursts of 4,4,2 separated by one IDLE
    do_reset();
    load(2, 10);
    run_until_done(60);
    check_burst(0, 2, 4);
    check_burst(1, 2, 4);
    check_burst(2, 2, 2);
    if (bursts.size() >= 3) begin
      chk("single_gap01", 32'(bursts[1].start - bursts[0].start), 32'd5);
      chk("single_gap12", 32'(bursts[2].start - bursts[1].start), 32'd5);
      chk("single_len2", 32'(bursts[2].len), 32'd3);
    end
    check_drained();

    // All requesters valid: rotation 0,1,2,3,0,... with 5 cycles per grant
    do_reset();
    for (int n = 0; n < NR; n++) load(n, 12);
    for (int i = 0; i < 40; i++) cyc();
    chk("allv_nbursts", 32'(bursts.size()), 32'd7);
    for (int k = 0; k < 7; k++) begin
      check_burst(k, k % NR, BL);
      if (k >= 1 && k < bursts.size())
        chk($sformatf("allv_gap%0d", k), 32'(bursts[k].start - bursts[k-1].start), 32'd5);
    end

    // Backpressure: ready toggles, each grant still moves exactly 4 beats
    do_reset();
    rdy_mode = 1;
    load(0, 8);
    load(1, 8);
    run_until_done(200);
    chk("bp_nbursts", 32'(bursts.size()), 32'd4);
    for (int k = 0; k < 4; k++) check_burst(k, k % 2, BL);
    check_drained();

    // Wrap: pointer at 3 with requesters 0 and 3 pending -> 3 then 0
    do_reset();
    load(2, 1);
    run_until_idle(20);
    load(0, 2);
    load(3, 2);
    run_until_done(40);
    check_burst(0, 2, 1);
    check_burst(1, 3, 2);
    check_burst(2, 0, 2);
    check_drained();

    // Wrap: after grant 3 with only requester 1 pending -> grant 1
    do_reset();
    load(2, 1);
    run_until_idle(20);
    load(3, 1);
    run_until_idle(20);
    load(1, 1);
    run_until_done(40);
    check_burst(0, 2, 1);
    check_burst(1, 3, 1);
    check_burst(2, 1, 1);
    check_drained();

    // Mid-burst reset after 2 beats of requester 3 (pointer was 3)
    do_reset();
    load(2, 1);
    run_until_idle(20);
    load(3, 6);
    cyc();
    cyc();
    cyc();
    load(1, 2);
    mid_reset(3);
    run_until_done(60);
    check_burst(0, 1, 2);
    check_burst(1, 3, 4);
    check_drained();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
